// File: rtl/vc707_reset_pkg.sv
// Shared types and defaults for the VC707 board-level reset controller.
package vc707_reset_pkg;

    typedef enum logic [1:0] {
        S_MMCM_RST  = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_HOLD      = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [3:0] FAIL_COUNT_MAX = 4'd15;

    localparam int DEF_SYNC_STAGES       = 3;
    localparam int DEF_HOLD_BITS         = 8;
    localparam int DEF_LOCK_TIMEOUT_BITS = 16;
    localparam int DEF_BTN_DEBOUNCE_BITS = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vc707_reset_debounce.sv
// Synchronizes an asynchronous level and only follows it after it has been
// stable for 2^DEBOUNCE_BITS consecutive cycles.
module vc707_reset_debounce #(
    parameter int SYNC_STAGES   = 3,
    parameter int DEBOUNCE_BITS = 10
) (
    input  logic clock,
    input  logic areset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0]   sync_reg;
    logic [DEBOUNCE_BITS-1:0] cnt_reg;
    logic                     din_s;

    assign din_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            sync_reg <= '0;
            cnt_reg  <= '0;
            dout     <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            // Any sample that agrees with the current output restarts the window.
            if (din_s == dout) begin
                cnt_reg <= '0;
            end else if (cnt_reg == '1) begin
                cnt_reg <= '0;
                dout    <= ~dout;
            end else begin
                cnt_reg <= cnt_reg + DEBOUNCE_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/vc707_reset_ctrl.sv
// Sequences MMCM reset, lock wait with timeout/retry and a post-lock hold,
// then releases the downstream asynchronous reset.
module vc707_reset_ctrl
    import vc707_reset_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int HOLD_BITS         = DEF_HOLD_BITS,
    parameter int LOCK_TIMEOUT_BITS = DEF_LOCK_TIMEOUT_BITS,
    parameter int BTN_DEBOUNCE_BITS = DEF_BTN_DEBOUNCE_BITS
) (
    input  logic       clock,
    input  logic       areset_n,
    input  logic       button,
    input  logic       mmcm_locked,
    input  logic       sw_reset_req,
    output logic       mmcm_reset,
    output logic       areset,
    output logic [1:0] state,
    output logic [3:0] fail_count
);

    localparam int              CNT_W     = max_int(HOLD_BITS, LOCK_TIMEOUT_BITS);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((1 << HOLD_BITS) - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'((1 << LOCK_TIMEOUT_BITS) - 1);

    logic [SYNC_STAGES-1:0] lock_sync_reg;
    logic                   locked_s;
    logic                   btn_db;
    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   timeout;

    assign locked_s = lock_sync_reg[SYNC_STAGES-1];
    assign state    = state_reg;

    vc707_reset_debounce #(
        .SYNC_STAGES   (SYNC_STAGES),
        .DEBOUNCE_BITS (BTN_DEBOUNCE_BITS)
    ) u_btn_debounce (
        .clock    (clock),
        .areset_n (areset_n),
        .din      (button),
        .dout     (btn_db)
    );

    always_comb begin
        state_next = state_reg;
        timeout    = 1'b0;
        case (state_reg)
            S_MMCM_RST: begin
                if (!btn_db && cnt_reg == HOLD_LAST) state_next = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (btn_db) begin
                    state_next = S_MMCM_RST;
                end else if (locked_s) begin
                    state_next = S_HOLD;
                end else if (cnt_reg == LOCK_LAST) begin
                    state_next = S_MMCM_RST;
                    timeout    = 1'b1;
                end
            end
            S_HOLD: begin
                if (!locked_s || btn_db)     state_next = S_MMCM_RST;
                else if (cnt_reg == HOLD_LAST) state_next = S_RUN;
            end
            S_RUN: begin
                if (!locked_s || btn_db)  state_next = S_MMCM_RST;
                else if (sw_reset_req)    state_next = S_HOLD;
            end
            default: state_next = S_MMCM_RST;
        endcase
    end

    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            lock_sync_reg <= '0;
            state_reg     <= S_MMCM_RST;
            cnt_reg       <= '0;
            mmcm_reset    <= 1'b1;
            areset        <= 1'b1;
            fail_count    <= '0;
        end else begin
            lock_sync_reg <= {lock_sync_reg[SYNC_STAGES-2:0], mmcm_locked};
            state_reg     <= state_next;
            mmcm_reset    <= (state_next == S_MMCM_RST);
            areset        <= (state_next != S_RUN);
            // A held button keeps the MMCM pulse timer parked so release always
            // yields a full-width pulse.
            if (state_next != state_reg || (state_reg == S_MMCM_RST && btn_db))
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + CNT_W'(1);
            if (timeout && fail_count != FAIL_COUNT_MAX)
                fail_count <= fail_count + 4'd1;
        end
    end

endmodule

// File: tb/tb_vc707_reset_ctrl.sv
// Directed vector bench for vc707_reset_ctrl with short counters.
module tb_vc707_reset_ctrl;

    logic       clock;
    logic       areset_n;
    logic       button;
    logic       mmcm_locked;
    logic       sw_reset_req;
    logic       mmcm_reset;
    logic       areset;
    logic [1:0] state;
    logic [3:0] fail_count;

    int vec_count = 0;
    int miscompares = 0;

    typedef struct {
        int         adv;
        logic       locked;
        logic       btn;
        logic       sw;
        logic [1:0] st;
        logic       mr;
        logic       ar;
        string      name;
    } vec_t;

    vec_t vecs[$];

    vc707_reset_ctrl #(
        .SYNC_STAGES       (3),
        .HOLD_BITS         (4),
        .LOCK_TIMEOUT_BITS (6),
        .BTN_DEBOUNCE_BITS (3)
    ) dut (
        .clock        (clock),
        .areset_n     (areset_n),
        .button       (button),
        .mmcm_locked  (mmcm_locked),
        .sw_reset_req (sw_reset_req),
        .mmcm_reset   (mmcm_reset),
        .areset       (areset),
        .state        (state),
        .fail_count   (fail_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [1:0] st, input logic mr,
                             input logic ar, input logic [3:0] fc);
        check({name, ".state"}, 4'(state), 4'(st));
        check({name, ".mmcm_reset"}, 4'(mmcm_reset), 4'(mr));
        check({name, ".areset"}, 4'(areset), 4'(ar));
        check({name, ".fail_count"}, fail_count, fc);
        $display("vec %-18s state=%0d mmcm_reset=%0b areset=%0b fail_count=%0d",
                 name, state, mmcm_reset, areset, fail_count);
    endtask

    task automatic add(input int adv, input logic lk, input logic bt, input logic sw,
                       input logic [1:0] st, input logic mr, input logic ar, input string nm);
        vec_t v;
        v.adv = adv; v.locked = lk; v.btn = bt; v.sw = sw;
        v.st = st; v.mr = mr; v.ar = ar; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        // Edge k below means the k-th rising edge after areset_n release.
        add(15, 0, 0, 0, 2'd0, 1, 1, "pwr_mrst_hold");
        add( 1, 0, 0, 0, 2'd1, 0, 1, "pwr_mrst_end");
        add( 4, 0, 0, 0, 2'd1, 0, 1, "pwr_wait");
        add( 3, 1, 0, 0, 2'd1, 0, 1, "lock_sync");
        add( 1, 1, 0, 0, 2'd2, 0, 1, "hold_entry");
        add(15, 1, 0, 0, 2'd2, 0, 1, "hold_end");
        add( 1, 1, 0, 0, 2'd3, 0, 0, "run_entry");
        add( 5, 1, 0, 0, 2'd3, 0, 0, "run_steady");
        add( 3, 0, 0, 0, 2'd3, 0, 0, "lockloss_sync");
        add( 1, 0, 0, 0, 2'd0, 1, 1, "lockloss_react");
        add(15, 1, 0, 0, 2'd0, 1, 1, "restart_mrst");
        add( 1, 1, 0, 0, 2'd1, 0, 1, "restart_wait");
        add( 1, 1, 0, 0, 2'd2, 0, 1, "restart_hold");
        add(16, 1, 0, 0, 2'd3, 0, 0, "restart_run");
        add( 1, 1, 0, 1, 2'd2, 0, 1, "sw_req_hold");
        add(15, 1, 0, 0, 2'd2, 0, 1, "sw_hold_end");
        add( 1, 1, 0, 0, 2'd3, 0, 0, "sw_run");
        add( 5, 1, 1, 0, 2'd3, 0, 0, "glitch_high");
        add(12, 1, 0, 0, 2'd3, 0, 0, "glitch_gone");
        add(11, 1, 1, 0, 2'd3, 0, 0, "press_debounce");
        add( 1, 1, 1, 0, 2'd0, 1, 1, "press_react");
        add( 8, 1, 1, 0, 2'd0, 1, 1, "press_held");
        add(11, 1, 0, 0, 2'd0, 1, 1, "release_debounce");
        add(15, 1, 0, 0, 2'd0, 1, 1, "release_mrst");
        add( 1, 1, 0, 0, 2'd1, 0, 1, "release_wait");
        add( 1, 1, 0, 0, 2'd2, 0, 1, "release_hold");
        add(16, 1, 0, 0, 2'd3, 0, 0, "release_run");

        areset_n     = 1'b0;
        button       = 1'b0;
        mmcm_locked  = 1'b0;
        sw_reset_req = 1'b0;
        step(3);
        check_all("reset_state", 2'd0, 1, 1, 4'd0);
        areset_n = 1'b1;

        foreach (vecs[i]) begin
            mmcm_locked  = vecs[i].locked;
            button       = vecs[i].btn;
            sw_reset_req = vecs[i].sw;
            step(1);
            sw_reset_req = 1'b0;
            step(vecs[i].adv - 1);
            check_all(vecs[i].name, vecs[i].st, vecs[i].mr, vecs[i].ar, 4'd0);
        end

        // Lock loss from edge 180, then a request during the lock wait is ignored.
        mmcm_locked = 1'b0;
        step(3);
        check_all("drop_sync", 2'd3, 0, 0, 4'd0);
        step(1);
        check_all("drop_react", 2'd0, 1, 1, 4'd0);
        step(16);
        check_all("wait_again", 2'd1, 0, 1, 4'd0);
        step(5);
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
        check_all("sw_in_wait", 2'd1, 0, 1, 4'd0);

        // Repeated timeouts: 64-cycle wait, 16-cycle MMCM pulse, count saturates.
        step(57);
        check_all("timeout_1_pre", 2'd1, 0, 1, 4'd0);
        step(1);
        check_all("timeout_1", 2'd0, 1, 1, 4'd1);
        for (int i = 2; i <= 16; i++) begin
            step(79);
            check_all($sformatf("timeout_%0d_pre", i), 2'd1, 0, 1, 4'((i - 1 > 15) ? 15 : i - 1));
            step(1);
            check_all($sformatf("timeout_%0d", i), 2'd0, 1, 1, 4'((i > 15) ? 15 : i));
        end

        // Reach S_HOLD, then assert areset_n between clock edges.
        mmcm_locked = 1'b1;
        step(17);
        check_all("hold_again", 2'd2, 0, 1, 4'd15);
        step(5);
        #2;
        areset_n = 1'b0;
        #1;
        check_all("async_reset", 2'd0, 1, 1, 4'd0);
        step(2);
        check_all("reset_held", 2'd0, 1, 1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
